// File: rtl/xd_pkg.sv
// Shared definitions for the cross-domain event synchroniser: per-channel
// event mode encoding.
package xd_pkg;

  localparam int unsigned XD_MODE_W = 2;

  typedef enum logic [XD_MODE_W-1:0] {
    XD_MODE_LEVEL  = 2'd0,
    XD_MODE_TOGGLE = 2'd1,
    XD_MODE_RISE   = 2'd2,
    XD_MODE_FALL   = 2'd3
  } xd_mode_t;

endpackage : xd_pkg

// File: rtl/xd_event_chan.sv
// One event channel: synchroniser chain, glitch filter, edge detection,
// sticky pending flag with acknowledge, and saturating event counter.
module xd_event_chan
  import xd_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_dst,
  input  logic              rst_dst,
  input  logic              async_in,
  input  xd_mode_t          mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              ack,
  input  logic              cnt_clr,
  output logic              level_out,
  output logic              pulse_out,
  output logic              pending,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0] s;
  logic              s_out;
  logic              flt;
  logic              flt_d;
  logic [FILT_W-1:0] fc;
  logic              ev;

  assign s_out = s[STAGES-1];

  // Synchroniser chain; s[0] is the only flop that samples the raw input.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], async_in};
    end
  end

  // A new level is accepted after L consecutive differing samples.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      flt   <= 1'b0;
      fc    <= '0;
      flt_d <= 1'b0;
    end else begin
      flt_d <= flt;
      if (s_out == flt) begin
        fc <= '0;
      end else if ((filt_len <= FILT_W'(1)) || (fc == (filt_len - FILT_W'(1)))) begin
        flt <= s_out;
        fc  <= '0;
      end else begin
        fc <= fc + FILT_W'(1);
      end
    end
  end

  // Edges come from filtered flops only, so mode changes cannot fake events.
  always_comb begin
    ev = 1'b0;
    case (mode)
      XD_MODE_TOGGLE: ev = flt ^ flt_d;
      XD_MODE_RISE:   ev = flt & ~flt_d;
      XD_MODE_FALL:   ev = ~flt & flt_d;
      default:        ev = 1'b0;
    endcase
  end

  assign level_out = flt;
  assign pulse_out = ev;

  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      pending <= 1'b0;
      count   <= '0;
    end else begin
      if (ev) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
      if (cnt_clr) begin
        count <= CNT_W'(ev);
      end else if (ev && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule : xd_event_chan

// File: rtl/xd_event_sync.sv
// Multi-channel asynchronous flag conditioner: NCH independent event
// channels with packed vector outputs.
module xd_event_sync
  import xd_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk_dst,
  input  logic                 rst_dst,
  input  logic [NCH-1:0]       async_in,
  input  logic [2*NCH-1:0]     mode,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [NCH-1:0]       ack,
  input  logic                 cnt_clr,
  output logic [NCH-1:0]       level_out,
  output logic [NCH-1:0]       pulse_out,
  output logic [NCH-1:0]       pending,
  output logic [NCH*CNT_W-1:0] count
);

  if (STAGES < 2) begin : g_bad_stages
    $error("xd_event_sync: STAGES must be >= 2");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("xd_event_sync: NCH must be >= 1");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    xd_event_chan #(
      .STAGES (STAGES),
      .FILT_W (FILT_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk_dst   (clk_dst),
      .rst_dst   (rst_dst),
      .async_in  (async_in[i]),
      .mode      (xd_mode_t'(mode[XD_MODE_W*i +: XD_MODE_W])),
      .filt_len  (filt_len),
      .ack       (ack[i]),
      .cnt_clr   (cnt_clr),
      .level_out (level_out[i]),
      .pulse_out (pulse_out[i]),
      .pending   (pending[i]),
      .count     (count[CNT_W*i +: CNT_W])
    );
  end

endmodule : xd_event_sync

// File: tb/tb_xd_event_sync.sv
// Directed self-checking bench for xd_event_sync at default parameters.
module tb_xd_event_sync;

  logic        clk_dst;
  logic        rst_dst;
  logic [3:0]  async_in;
  logic [7:0]  mode;
  logic [3:0]  filt_len;
  logic [3:0]  ack;
  logic        cnt_clr;
  logic [3:0]  level_out;
  logic [3:0]  pulse_out;
  logic [3:0]  pending;
  logic [31:0] count;

  int n_checks;
  int n_errors;

  xd_event_sync dut (
    .clk_dst   (clk_dst),
    .rst_dst   (rst_dst),
    .async_in  (async_in),
    .mode      (mode),
    .filt_len  (filt_len),
    .ack       (ack),
    .cnt_clr   (cnt_clr),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .pending   (pending),
    .count     (count)
  );

  initial clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each call advances n rising edges; inputs change and outputs are sampled
  // on falling edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_dst);
  endtask

  task automatic clear_all();
    ack     = 4'hF;
    cnt_clr = 1'b1;
    tick(1);
    ack     = 4'h0;
    cnt_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // ch0 toggle, ch1 rise, ch2 fall, ch3 level
    mode     = 8'h39;
    rst_dst  = 1'b1;
    async_in = 4'hF;
    filt_len = 4'd0;
    ack      = 4'h0;
    cnt_clr  = 1'b0;

    // Reset with inputs high, then release
    tick(4);
    chk("rst_level", 32'(level_out), 32'h0);
    chk("rst_pulse", 32'(pulse_out), 32'h0);
    chk("rst_pend",  32'(pending),   32'h0);
    chk("rst_count", count,          32'h0);
    rst_dst = 1'b0;
    tick(2);
    chk("rel_level_e2", 32'(level_out), 32'h0);
    tick(1);
    chk("rel_level_e3", 32'(level_out), 32'hF);
    chk("rel_pulse_e3", 32'(pulse_out), 32'h3);
    tick(1);
    chk("rel_pulse_e4", 32'(pulse_out), 32'h0);
    chk("rel_pend",     32'(pending),   32'h3);
    chk("rel_count",    count,          32'h0000_0101);
    clear_all();
    chk("clr_pend",  32'(pending), 32'h0);
    chk("clr_count", count,        32'h0);

    // All low: toggle ch0 and fall ch2 fire
    async_in = 4'h0;
    tick(3);
    chk("fall_pulse", 32'(pulse_out), 32'h5);
    tick(1);
    chk("fall_count", count, 32'h0001_0001);
    clear_all();

    // Toggle / rise / fall on ch0..ch2
    async_in = 4'h7;
    tick(2);
    chk("trf_lat_e2", 32'(level_out), 32'h0);
    tick(1);
    chk("trf_level_hi", 32'(level_out), 32'h7);
    chk("trf_pulse_hi", 32'(pulse_out), 32'h3);
    tick(1);
    chk("trf_pulse_one", 32'(pulse_out), 32'h0);
    chk("trf_pend_hi",   32'(pending),   32'h3);
    chk("trf_count_hi",  count,          32'h0000_0101);
    async_in = 4'h0;
    tick(3);
    chk("trf_level_lo", 32'(level_out), 32'h0);
    chk("trf_pulse_lo", 32'(pulse_out), 32'h5);
    tick(1);
    chk("trf_pend_lo",  32'(pending), 32'h7);
    chk("trf_count_lo", count,        32'h0001_0102);
    clear_all();

    // Filter L=4: 3-cycle glitch is rejected
    filt_len = 4'd4;
    async_in[0] = 1'b1;
    tick(3);
    async_in[0] = 1'b0;
    tick(8);
    chk("glitch_level", 32'(level_out), 32'h0);
    chk("glitch_count", count,          32'h0);
    chk("glitch_pend",  32'(pending),   32'h0);

    // 4-cycle high is accepted at edge 6
    async_in[0] = 1'b1;
    tick(4);
    async_in[0] = 1'b0;
    tick(1);
    chk("wide_level_e5", 32'(level_out), 32'h0);
    tick(1);
    chk("wide_level_e6", 32'(level_out), 32'h1);
    chk("wide_pulse_e6", 32'(pulse_out), 32'h1);
    tick(1);
    chk("wide_pend",  32'(pending), 32'h1);
    chk("wide_count", count,        32'h1);
    tick(6);
    chk("wide_level_back", 32'(level_out), 32'h0);
    chk("wide_count_back", count,          32'h2);

    // Chatter H-H-L-H... restarts the filter count: accept at edge 9
    async_in[0] = 1'b1;
    tick(2);
    async_in[0] = 1'b0;
    tick(1);
    async_in[0] = 1'b1;
    tick(5);
    chk("chat_level_e8", 32'(level_out), 32'h0);
    tick(1);
    chk("chat_level_e9", 32'(level_out), 32'h1);
    async_in[0] = 1'b0;
    tick(14);
    chk("chat_level_back", 32'(level_out), 32'h0);
    filt_len = 4'd1;
    clear_all();
    tick(1);

    // ack coincident with event: event wins
    async_in[0] = 1'b1;
    tick(3);
    chk("ack_pulse", 32'(pulse_out), 32'h1);
    ack = 4'h1;
    tick(1);
    ack = 4'h0;
    chk("ack_coinc_pend", 32'(pending), 32'h1);
    ack = 4'h1;
    tick(1);
    ack = 4'h0;
    chk("ack_clear_pend", 32'(pending), 32'h0);

    // Saturation: toggle every cycle
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      async_in[0] = ~async_in[0];
      tick(1);
    end
    tick(4);
    chk("sat_count_200", count, 32'h0000_00C8);
    for (int i = 0; i < 60; i++) begin
      async_in[0] = ~async_in[0];
      tick(1);
    end
    tick(4);
    chk("sat_count_max", count, 32'h0000_00FF);
    chk("sat_level",     32'(level_out), 32'h1);

    // cnt_clr coincident with event
    async_in[0] = 1'b0;
    tick(3);
    chk("clrev_pulse", 32'(pulse_out), 32'h1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("clrev_count", count, 32'h1);

    // Async reset mid-filter with pending set
    chk("mid_pend_before", 32'(pending), 32'h1);
    filt_len = 4'd4;
    async_in[0] = 1'b1;
    tick(3);
    #2 rst_dst = 1'b1;
    #1;
    chk("mid_level", 32'(level_out), 32'h0);
    chk("mid_pulse", 32'(pulse_out), 32'h0);
    chk("mid_pend",  32'(pending),   32'h0);
    chk("mid_count", count,          32'h0);
    async_in = 4'h0;
    tick(2);
    rst_dst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("post_rst_pulse", 32'(pulse_out), 32'h0);
      chk("post_rst_level", 32'(level_out), 32'h0);
    end
    chk("post_rst_count", count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_xd_event_sync

// File: doc/xd_event_sync.md
# xd_event_sync

Multi-channel, single-clock input conditioner. It brings up to NCH asynchronous flags into the `clk_dst` domain through a configurable synchroniser chain and an optional glitch filter. It then detects per-channel events (toggle, rise or fall) and exposes them three ways: as one-cycle pulses, as sticky pending bits with an acknowledge handshake, and as saturating event counters. It sits at the boundary where external or foreign-domain flags enter a clock domain, and it replaces ad-hoc per-flag synchroniser instances.

## Interface
Parameters:
- `NCH`, 4, number of channels (1..16)
- `STAGES`, 2, synchroniser flops per channel (2..8)
- `FILT_W`, 4, width of the filter length and filter counters
- `CNT_W`, 8, width of each event counter

Ports:
- `clk_dst`  in  1  the only clock
- `rst_dst`  in  1  asynchronous, active-high reset
- `async_in`  in  NCH  asynchronous flag inputs, one per channel
- `mode`  in  2*NCH  per-channel mode, channel i at [2i+1:2i]; 0=level, 1=toggle, 2=rise, 3=fall; treated as synchronous
- `filt_len`  in  FILT_W  filter length L, shared by all channels; 0 and 1 both mean bypass
- `ack`  in  NCH  per-channel clear for `pending`
- `cnt_clr`  in  1  synchronous clear of all counters
- `level_out`  out  NCH  filtered, synchronised level
- `pulse_out`  out  NCH  one-cycle event strobe
- `pending`  out  NCH  sticky event flag
- `count`  out  NCH*CNT_W  event counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]

## Operation
The following applies per channel, with all channels independent.
- **Synchroniser:** `s[0..STAGES-1]` shifts `async_in` each clock. `s_out = s[STAGES-1]`.
- **Filter:** holds a stable register `flt` and a counter `fc`.
  - If `s_out == flt`: `fc <= 0`.
  - Otherwise, if L <= 1 or `fc == L-1`: `flt <= s_out`, `fc <= 0`. Otherwise `fc <= fc+1`.
  - Net effect: a new level is accepted only after `s_out` has differed from `flt` on L consecutive edges. Any return to `flt` restarts the count.
- **Delay register:** `flt_d <= flt` every clock.
- **Event `ev`** is combinational from flops only:
  - toggle mode: `flt ^ flt_d`
  - rise mode: `flt & ~flt_d`
  - fall mode: `~flt & flt_d`
  - level mode: 0
- **Outputs:**
  - `level_out = flt`
  - `pulse_out = ev`
- **Pending:** set on `ev`, cleared on `ack`. If `ev` and `ack` occur in the same cycle, the result is 1 (the event wins).
- **Count:**
  - Increments on `ev` and saturates at 2^CNT_W-1. It does not wrap.
  - `cnt_clr` alone sets the count to 0.
  - `cnt_clr` together with `ev` sets the count to 1.
- **Mode changes** take effect in the same cycle. They never create events by themselves, because edge detection uses `flt`/`flt_d` only.
- **Reset:** all flops clear to 0 (`s`, `flt`, `flt_d`, `fc`, `pending`, `count`). An input that is held at 1 through reset produces a rising event after release; this is intended.

## Timing
- **Reset values:** all outputs are 0.
- **Level latency:** `async_in` is stable before edge 1. `flt` (and therefore `level_out`) updates at edge `STAGES + max(L,1)`.
- **Pulse:** `pulse_out` is high for exactly one cycle, starting at the same edge as the `level_out` change.
- **Pending and count:** both update at the following edge.
- **Minimum event spacing:** back-to-back toggles on `flt` are 1 cycle apart and give consecutive pulses, so no events are lost.
- **Async reset mid-operation:** all outputs are 0 immediately. Partial filter counts are discarded.

## Structure
- Shared package `xd_pkg`:
  - mode encodings `XD_MODE_LEVEL`, `XD_MODE_TOGGLE`, `XD_MODE_RISE`, `XD_MODE_FALL`
  - the 2-bit mode typedef
- Sub-module `xd_event_chan`: one channel containing the synchroniser, filter, edge detection, pending flag and counter. The top level generates NCH instances and packs the vector outputs.
- Parameter checks run at elaboration: `STAGES >= 2` and `NCH >= 1`.

## Test plan
Default parameters (NCH=4, STAGES=2, CNT_W=8) unless noted.
- **Reset:** assert `rst_dst` with `async_in=4'hF` -> all outputs 0. Release with input still high -> `level_out` = 4'hF after edge 3. Channels in toggle or rise mode pulse once and reach `count` = 1.
- **Toggle mode, L=0, ch0:** rise at edge 0 -> `level_out[0]` and `pulse_out[0]` high from edge 3, pulse for one cycle, then `pending[0]`=1 and `count[0]`=1. A later fall -> a second pulse and `count[0]`=2.
- **Rise and fall modes:** ch1 in rise mode and ch2 in fall mode, both driven high and then low -> ch1 pulses only on the rise, ch2 only on the fall, and each count = 1.
- **Filter, L=4:**
  - A 3-cycle high glitch -> `level_out` and `count` unchanged.
  - A 4-cycle-wide high -> `level_out` rises at edge 6 after the input edge.
  - Chatter H-L-H before acceptance -> the filter count restarts.
- **Handshake and saturation:**
  - `ack` in the same cycle as an event -> `pending` stays 1.
  - 256 events -> `count` = 255 (held).
  - `cnt_clr` coincident with an event -> `count` = 1.
- **Mid-operation reset:** assert `rst_dst` during filter counting and while `pending` is set -> all outputs are 0 immediately, and after release no stale pulse appears for a low input.
